mem_stage_lsu: RTL and testbench
================================

# mem_stage_lsu

Parametrised memory stage for the five-stage pipeline. It sits between the EX/M pipeline register and the M/W register. It takes the decoded load/store request, the ALU address, the forwarded store data and the destination register, and drives a variable-latency data-memory bus with a req/gnt/rvalid handshake. It supports byte, half, word and (at DATA_W=64) double accesses with sign/zero extension, stalls the pipeline while memory is busy, and presents a registered writeback result (rd address and value) to the W stage.

## Interface
- DATA_W, 32: data/register width; 32 or 64 only.
- ADDR_W, 32: byte-address width.
- RA_W, 5: register-address width.
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- in_valid  in  1  M-stage instruction present.
- in_ready  out  1  stage can accept; 0 stalls upstream.
- in_pc  in  32  PC of instruction, carried to output.
- in_rd  in  RA_W  destination register (0 = no write).
- in_rd_val  in  DATA_W  non-load writeback value.
- in_ld  in  1  load.
- in_st  in  1  store; in_ld and in_st both 1 is illegal.
- in_size  in  2  0 byte, 1 half, 2 word, 3 double (DATA_W=64 only).
- in_signed  in  1  sign-extend load.
- in_addr  in  ADDR_W  byte address (ALU result).
- in_wdata  in  DATA_W  forwarded store data.
- mem_req  out  1  bus request.
- mem_we  out  1  write request.
- mem_addr  out  ADDR_W  address with the low log2(DATA_W/8) bits forced to 0.
- mem_be  out  DATA_W/8  byte enables.
- mem_wdata  out  DATA_W  lane-replicated store data.
- mem_gnt  in  1  request accepted this cycle.
- mem_rvalid  in  1  read data valid.
- mem_rdata  in  DATA_W  read data.
- out_valid  out  1  result valid toward W.
- out_ready  in  1  W accepts.
- out_pc  out  32  PC of the result.
- out_rd  out  RA_W  writeback register.
- out_rd_val  out  DATA_W  writeback value.
- out_exc  out  1  misaligned access (only with MEM_ALIGN_CHECK_EN).

## Operation
- FSM states: IDLE, REQ, WAIT.
  - IDLE to REQ: accepted load or store.
  - REQ to WAIT: load with mem_gnt.
  - REQ to IDLE: store with mem_gnt; the result is loaded into the output register (out_rd = in_rd, out_rd_val = in_rd_val).
  - WAIT to IDLE: mem_rvalid; the extracted load data is loaded into the output register.
- in_ready = (state == IDLE) && (!out_valid || out_ready). Acceptance = in_valid && in_ready.
- Non-memory instruction: accepted in IDLE and written straight into the output register; the FSM stays in IDLE.
- mem_req = (state == REQ). mem_addr, mem_be, mem_we and mem_wdata come from the request registers and are held stable until mem_gnt.
- Byte offset off = addr[log2(DATA_W/8)-1:0].
  - mem_be: (2^(2^size) - 1) << off.
  - mem_wdata: the low 2^size bytes of in_wdata replicated across all lanes.
- Load extraction: mem_rdata >> (8*off), truncated to 2^size bytes, then sign- or zero-extended to DATA_W.
- mem_rvalid in IDLE or REQ is ignored. mem_gnt outside REQ is ignored.
- Output register: out_valid stays set with stable data until out_ready. It clears on out_ready unless a new result is loaded in the same cycle.

## Timing
- Reset (asynchronous, reset = 0):
  - state = IDLE.
  - mem_req = 0, mem_we = 0, mem_be = 0, mem_addr = 0, mem_wdata = 0.
  - out_valid = 0, out_pc = 0, out_rd = 0, out_rd_val = 0, out_exc = 0.
  - Reset mid-transaction abandons it; a late rvalid is ignored.
- Latencies, counted from the accept edge (mem_gnt and mem_rvalid assumed immediate):
  - Non-memory instruction: out_valid 1 cycle later.
  - Store: mem_req in cycle +1, out_valid at +2.
  - Load: mem_req at +1, WAIT at +2, rvalid in cycle +2, out_valid at +3.
  - Each cycle without gnt or rvalid adds one cycle.
- Back-to-back: the next instruction is accepted in the cycle the FSM is back in IDLE, provided the output register is free or draining.
- Stall: in_ready = 0 whenever state != IDLE, or whenever out_valid && !out_ready.

## Configuration
- MEM_ALIGN_CHECK_EN defined:
  - An access where off is not a multiple of 2^size is not sent to memory (no mem_req).
  - It completes like a non-memory instruction with out_exc = 1 and out_rd = 0.
  - out_exc clears with the next result.
- MEM_ALIGN_CHECK_EN undefined:
  - The low log2(2^size) address bits are forced to 0 before offset calculation.
  - out_exc is tied to 0.

## Test plan
- Reset mid-load:
  - Stimulus: DATA_W=32; lw at 0x10; hold mem_gnt = 0 for 3 cycles, then pull reset low.
  - Required: mem_req = 0 and out_valid = 0 immediately. A later rvalid produces no output.
- Signed and unsigned byte loads:
  - Stimulus: lb at 0x13 with mem_rdata = 0x80FF_FF01.
  - Required: out_rd_val = 0xFFFF_FF80.
  - Stimulus: same access as lbu.
  - Required: 0x0000_0080.
  - Check mem_addr = 0x10.
- Halfword store:
  - Stimulus: sh at 0x22 with in_wdata = 0x1234_ABCD.
  - Required: mem_be = 4'b1100, mem_wdata = 0xABCD_ABCD, mem_addr = 0x20. out_valid follows 1 cycle after mem_gnt.
- Variable-latency load:
  - Stimulus: gnt delayed 2 cycles, rvalid delayed 3 cycles.
  - Required: in_ready = 0 throughout. Load returns at accept + 8. The following ALU instruction comes out exactly 1 cycle after it is accepted.
- Output backpressure:
  - Stimulus: out_ready = 0 for 4 cycles after an ALU result (rd = 5, value 0x7).
  - Required: outputs held stable and in_ready = 0. They drain on the out_ready edge, and the next instruction is accepted in that same cycle.
- MEM_ALIGN_CHECK_EN:
  - Stimulus: lw at 0x6.
  - Required: no mem_req, out_exc = 1, out_rd = 0.
  - With the macro undefined: access at 0x4 and out_exc = 0.
- DATA_W=64:
  - Stimulus: ld at 0x8 with mem_rdata = 0x0123_4567_89AB_CDEF.
  - Required: same value out, mem_be = 8'hFF.

Source files
------------

// File: rtl/mem_stage_lsu_if.sv
// Data-memory bus between the LSU (master) and the data memory (slave).
// req/gnt accept a request; rvalid/rdata return read data.
interface mem_stage_lsu_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32
);
  localparam int unsigned BE_W = DATA_W / 8;

  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [BE_W-1:0]   be;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req, we, addr, be, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, be, wdata,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/mem_stage_lsu.sv
// Memory stage of the five-stage pipeline: issues loads/stores on a
// req/gnt/rvalid bus, extracts/extends load data and holds a registered
// writeback result for W.
// Optional feature macro: MEM_ALIGN_CHECK_EN (misaligned accesses raise
// out_exc instead of going to memory; otherwise low address bits are dropped).
module mem_stage_lsu #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned RA_W   = 5
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [31:0]       in_pc_i,
  input  logic [RA_W-1:0]   in_rd_i,
  input  logic [DATA_W-1:0] in_rd_val_i,
  input  logic              in_ld_i,
  input  logic              in_st_i,
  input  logic [1:0]        in_size_i,
  input  logic              in_signed_i,
  input  logic [ADDR_W-1:0] in_addr_i,
  input  logic [DATA_W-1:0] in_wdata_i,
  mem_stage_lsu_if.master   mem,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [31:0]       out_pc_o,
  output logic [RA_W-1:0]   out_rd_o,
  output logic [DATA_W-1:0] out_rd_val_o,
  output logic              out_exc_o
);
  localparam int unsigned BE_W     = DATA_W / 8;
  localparam int unsigned OFF_W    = $clog2(BE_W);
  localparam logic [1:0]  MAX_SIZE = 2'(OFF_W);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_WAIT = 2'd2} state_e;
  state_e state_q, state_d;

  logic              req_q, req_d, we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [BE_W-1:0]   be_q;
  logic [DATA_W-1:0] wdata_q, rd_val_q;
  logic [31:0]       pc_q;
  logic [RA_W-1:0]   rd_q;
  logic [1:0]        size_q;
  logic              signed_q;
  logic [OFF_W-1:0]  off_q;

  logic              out_valid_q, out_valid_d, out_exc_q, out_exc_d;
  logic [31:0]       out_pc_q, out_pc_d;
  logic [RA_W-1:0]   out_rd_q, out_rd_d;
  logic [DATA_W-1:0] out_rd_val_q, out_rd_val_d;

  logic              accept, is_mem, misal, load_out, cap_req;
  logic [1:0]        sz;
  logic [OFF_W-1:0]  mask, off;
  logic [BE_W-1:0]   be_base, be_c;
  logic [DATA_W-1:0] wdata_rep, shifted, ld_data;

  assign in_ready_o = (state_q == S_IDLE) && (!out_valid_q || out_ready_i);
  assign accept     = in_valid_i && in_ready_o;
  assign is_mem     = in_ld_i || in_st_i;

  // Decode incoming access: size clamp, lane offset, byte enables, replicated store data
  always_comb begin
    sz = (in_size_i > MAX_SIZE) ? MAX_SIZE : in_size_i;
    case (sz)
      2'd0: begin
        mask      = '0;
        be_base   = BE_W'(1);
        wdata_rep = {(DATA_W/8){in_wdata_i[7:0]}};
      end
      2'd1: begin
        mask      = OFF_W'(1);
        be_base   = BE_W'(3);
        wdata_rep = {(DATA_W/16){in_wdata_i[15:0]}};
      end
      2'd2: begin
        mask      = OFF_W'(3);
        be_base   = BE_W'(15);
        wdata_rep = {(DATA_W/32){in_wdata_i[31:0]}};
      end
      default: begin
        mask      = OFF_W'(7);
        be_base   = '1;
        wdata_rep = in_wdata_i;
      end
    endcase
`ifdef MEM_ALIGN_CHECK_EN
    off   = in_addr_i[OFF_W-1:0];
    misal = (off & mask) != '0;
`else
    off   = in_addr_i[OFF_W-1:0] & ~mask;
    misal = 1'b0;
`endif
    be_c = be_base << off;
  end

  // Align returned read data to bit 0, then sign- or zero-extend by size
  always_comb begin
    shifted = mem.rdata >> {off_q, 3'b000};
    ld_data = shifted;
    case (size_q)
      2'd0: begin
        ld_data      = {DATA_W{signed_q & shifted[7]}};
        ld_data[7:0] = shifted[7:0];
      end
      2'd1: begin
        ld_data       = {DATA_W{signed_q & shifted[15]}};
        ld_data[15:0] = shifted[15:0];
      end
      2'd2: begin
        ld_data       = {DATA_W{signed_q & shifted[31]}};
        ld_data[31:0] = shifted[31:0];
      end
      default: ld_data = shifted;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept && is_mem && !misal) state_d = S_REQ;
      S_REQ:   if (mem.gnt) state_d = we_q ? S_IDLE : S_WAIT;
      S_WAIT:  if (mem.rvalid) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs: request capture/release and result selection for the output register
  always_comb begin
    load_out     = 1'b0;
    cap_req      = 1'b0;
    req_d        = req_q;
    out_pc_d     = in_pc_i;
    out_rd_d     = in_rd_i;
    out_rd_val_d = in_rd_val_i;
    out_exc_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (is_mem && !misal) begin
            cap_req = 1'b1;
            req_d   = 1'b1;
          end else begin
            load_out = 1'b1;
            if (is_mem) begin
              out_rd_d  = '0;
              out_exc_d = 1'b1;
            end
          end
        end
      end
      S_REQ: begin
        if (mem.gnt) begin
          req_d = 1'b0;
          if (we_q) begin
            load_out     = 1'b1;
            out_pc_d     = pc_q;
            out_rd_d     = rd_q;
            out_rd_val_d = rd_val_q;
          end
        end
      end
      S_WAIT: begin
        if (mem.rvalid) begin
          load_out     = 1'b1;
          out_pc_d     = pc_q;
          out_rd_d     = rd_q;
          out_rd_val_d = ld_data;
        end
      end
      default: ;
    endcase
    out_valid_d = load_out || (out_valid_q && !out_ready_i);
  end

  // Request registers: held stable from acceptance until mem_gnt
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      be_q     <= '0;
      wdata_q  <= '0;
      pc_q     <= '0;
      rd_q     <= '0;
      rd_val_q <= '0;
      size_q   <= '0;
      signed_q <= 1'b0;
      off_q    <= '0;
    end else begin
      req_q <= req_d;
      if (cap_req) begin
        we_q     <= in_st_i;
        addr_q   <= {in_addr_i[ADDR_W-1:OFF_W], OFF_W'(0)};
        be_q     <= be_c;
        wdata_q  <= wdata_rep;
        pc_q     <= in_pc_i;
        rd_q     <= in_rd_i;
        rd_val_q <= in_rd_val_i;
        size_q   <= sz;
        signed_q <= in_signed_i;
        off_q    <= off;
      end
    end
  end

  // Writeback output register toward W
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_valid_q  <= 1'b0;
      out_pc_q     <= '0;
      out_rd_q     <= '0;
      out_rd_val_q <= '0;
      out_exc_q    <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      if (load_out) begin
        out_pc_q     <= out_pc_d;
        out_rd_q     <= out_rd_d;
        out_rd_val_q <= out_rd_val_d;
        out_exc_q    <= out_exc_d;
      end
    end
  end

  assign mem.req      = req_q;
  assign mem.we       = we_q;
  assign mem.addr     = addr_q;
  assign mem.be       = be_q;
  assign mem.wdata    = wdata_q;
  assign out_valid_o  = out_valid_q;
  assign out_pc_o     = out_pc_q;
  assign out_rd_o     = out_rd_q;
  assign out_rd_val_o = out_rd_val_q;
  assign out_exc_o    = out_exc_q;
endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: one 32-bit and one 64-bit instance.
`timescale 1ns/1ps
module tb_mem_stage_lsu;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  int total = 0;
  int bad   = 0;

  // 32-bit instance
  logic        in_valid, in_ready, in_ld, in_st, in_signed;
  logic        out_valid, out_ready, out_exc;
  logic [31:0] in_pc, in_rd_val, in_addr, in_wdata, out_pc, out_rd_val;
  logic [4:0]  in_rd, out_rd;
  logic [1:0]  in_size;

  mem_stage_lsu_if #(.DATA_W(32), .ADDR_W(32)) m32 ();

  mem_stage_lsu #(.DATA_W(32), .ADDR_W(32), .RA_W(5)) u_dut32 (
    .clk_i(clk), .rst_ni(rst_n),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_pc_i(in_pc),
    .in_rd_i(in_rd), .in_rd_val_i(in_rd_val), .in_ld_i(in_ld), .in_st_i(in_st),
    .in_size_i(in_size), .in_signed_i(in_signed), .in_addr_i(in_addr),
    .in_wdata_i(in_wdata), .mem(m32.master),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_pc_o(out_pc),
    .out_rd_o(out_rd), .out_rd_val_o(out_rd_val), .out_exc_o(out_exc)
  );

  // 64-bit instance
  logic        in_valid64, in_ready64, in_ld64, in_st64, in_signed64;
  logic        out_valid64, out_ready64, out_exc64;
  logic [31:0] in_pc64, in_addr64, out_pc64;
  logic [63:0] in_rd_val64, in_wdata64, out_rd_val64;
  logic [4:0]  in_rd64, out_rd64;
  logic [1:0]  in_size64;

  mem_stage_lsu_if #(.DATA_W(64), .ADDR_W(32)) m64 ();

  mem_stage_lsu #(.DATA_W(64), .ADDR_W(32), .RA_W(5)) u_dut64 (
    .clk_i(clk), .rst_ni(rst_n),
    .in_valid_i(in_valid64), .in_ready_o(in_ready64), .in_pc_i(in_pc64),
    .in_rd_i(in_rd64), .in_rd_val_i(in_rd_val64), .in_ld_i(in_ld64), .in_st_i(in_st64),
    .in_size_i(in_size64), .in_signed_i(in_signed64), .in_addr_i(in_addr64),
    .in_wdata_i(in_wdata64), .mem(m64.master),
    .out_valid_o(out_valid64), .out_ready_i(out_ready64), .out_pc_o(out_pc64),
    .out_rd_o(out_rd64), .out_rd_val_o(out_rd_val64), .out_exc_o(out_exc64)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drv(input logic ld, input logic st, input logic [1:0] size, input logic sgn,
                     input logic [31:0] addr, input logic [4:0] rd, input logic [31:0] rdval,
                     input logic [31:0] wdata, input logic [31:0] pc);
    in_valid  = 1'b1;
    in_ld     = ld;
    in_st     = st;
    in_size   = size;
    in_signed = sgn;
    in_addr   = addr;
    in_rd     = rd;
    in_rd_val = rdval;
    in_wdata  = wdata;
    in_pc     = pc;
  endtask

  // Load with gd cycles of withheld gnt and rvd cycles of withheld rvalid
  task automatic run_ld(input string tag, input logic [31:0] addr, input logic [1:0] size,
                        input logic sgn, input logic [31:0] rdata, input int gd, input int rvd,
                        input logic [31:0] exp_addr, input logic [3:0] exp_be,
                        input logic [31:0] exp_val);
    drv(1'b1, 1'b0, size, sgn, addr, 5'd3, 32'h0, 32'h0, 32'h100 + addr);
    #1 chk({tag, "_rdy"}, in_ready, 1'b1);
    step();
    in_valid = 1'b0;
    chk({tag, "_we"}, m32.we, 1'b0);
    for (int k = 0; k <= gd; k++) begin
      m32.gnt = (k == gd);
      chk({tag, "_req"}, m32.req, 1'b1);
      chk({tag, "_addr"}, m32.addr, exp_addr);
      chk({tag, "_be"}, m32.be, exp_be);
      #1 chk({tag, "_stall_g"}, in_ready, 1'b0);
      step();
    end
    m32.gnt = 1'b0;
    chk({tag, "_req_off"}, m32.req, 1'b0);
    for (int k = 0; k <= rvd; k++) begin
      m32.rvalid = (k == rvd);
      m32.rdata  = (k == rvd) ? rdata : 32'hDEAD_BEEF;
      chk({tag, "_pend"}, out_valid, 1'b0);
      #1 chk({tag, "_stall_r"}, in_ready, 1'b0);
      step();
    end
    m32.rvalid = 1'b0;
    chk({tag, "_ov"}, out_valid, 1'b1);
    chk({tag, "_rd"}, out_rd, 5'd3);
    chk({tag, "_val"}, out_rd_val, exp_val);
    chk({tag, "_pc"}, out_pc, 32'h100 + addr);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; in_ld = 1'b0; in_st = 1'b0; in_signed = 1'b0; in_size = 2'd0;
    in_pc = '0; in_rd = '0; in_rd_val = '0; in_addr = '0; in_wdata = '0;
    out_ready = 1'b1;
    m32.gnt = 1'b0; m32.rvalid = 1'b0; m32.rdata = '0;
    in_valid64 = 1'b0; in_ld64 = 1'b0; in_st64 = 1'b0; in_signed64 = 1'b0; in_size64 = 2'd0;
    in_pc64 = '0; in_rd64 = '0; in_rd_val64 = '0; in_addr64 = '0; in_wdata64 = '0;
    out_ready64 = 1'b1;
    m64.gnt = 1'b0; m64.rvalid = 1'b0; m64.rdata = '0;
    step();
    step();

    // Reset values
    chk("rst_req", m32.req, 1'b0);
    chk("rst_we", m32.we, 1'b0);
    chk("rst_be", m32.be, 4'h0);
    chk("rst_addr", m32.addr, 32'h0);
    chk("rst_wdata", m32.wdata, 32'h0);
    chk("rst_ov", out_valid, 1'b0);
    chk("rst_pc", out_pc, 32'h0);
    chk("rst_rd", out_rd, 5'd0);
    chk("rst_val", out_rd_val, 32'h0);
    chk("rst_exc", out_exc, 1'b0);
    chk("rst_rdy", in_ready, 1'b1);
    chk("rst_ov64", out_valid64, 1'b0);
    rst_n = 1'b1;
    step();

    // Byte loads at offset 3, signed then unsigned; halfword signed
    run_ld("lb", 32'h13, 2'd0, 1'b1, 32'h80FF_FF01, 0, 0, 32'h10, 4'b1000, 32'hFFFF_FF80);
    run_ld("lbu", 32'h13, 2'd0, 1'b0, 32'h80FF_FF01, 0, 0, 32'h10, 4'b1000, 32'h0000_0080);
    run_ld("lh", 32'h12, 2'd1, 1'b1, 32'h80FF_FF01, 1, 0, 32'h10, 4'b1100, 32'hFFFF_80FF);

    // Variable latency load, then an ALU op one cycle behind it
    run_ld("lw_var", 32'h40, 2'd2, 1'b0, 32'h1122_3344, 2, 3, 32'h40, 4'hF, 32'h1122_3344);
    drv(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 5'd9, 32'h0ABC, 32'h0, 32'h200);
    #1 chk("alu_rdy", in_ready, 1'b1);
    step();
    in_valid = 1'b0;
    chk("alu_ov", out_valid, 1'b1);
    chk("alu_rd", out_rd, 5'd9);
    chk("alu_val", out_rd_val, 32'h0ABC);

    // Halfword store at 0x22, gnt withheld one cycle
    drv(1'b0, 1'b1, 2'd1, 1'b0, 32'h22, 5'd4, 32'h55, 32'h1234_ABCD, 32'h300);
    #1 chk("sh_rdy", in_ready, 1'b1);
    step();
    in_valid = 1'b0;
    chk("sh_req", m32.req, 1'b1);
    chk("sh_we", m32.we, 1'b1);
    chk("sh_be", m32.be, 4'b1100);
    chk("sh_wdata", m32.wdata, 32'hABCD_ABCD);
    chk("sh_addr", m32.addr, 32'h20);
    chk("sh_ov0", out_valid, 1'b0);
    step();
    chk("sh_req_hold", m32.req, 1'b1);
    chk("sh_wdata_hold", m32.wdata, 32'hABCD_ABCD);
    m32.gnt = 1'b1;
    step();
    m32.gnt = 1'b0;
    chk("sh_ov", out_valid, 1'b1);
    chk("sh_rd", out_rd, 5'd4);
    chk("sh_val", out_rd_val, 32'h55);
    chk("sh_req_off", m32.req, 1'b0);

    // Output backpressure: rd=5 value 7 held for 4 cycles, next op waits
    drv(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 5'd5, 32'h7, 32'h0, 32'h400);
    step();
    drv(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 5'd6, 32'h99, 32'h0, 32'h404);
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1 chk("bp_rdy", in_ready, 1'b0);
      chk("bp_ov", out_valid, 1'b1);
      chk("bp_rd", out_rd, 5'd5);
      chk("bp_val", out_rd_val, 32'h7);
      step();
    end
    out_ready = 1'b1;
    #1 chk("bp_drain_rdy", in_ready, 1'b1);
    step();
    in_valid = 1'b0;
    chk("bp_next_ov", out_valid, 1'b1);
    chk("bp_next_rd", out_rd, 5'd6);
    chk("bp_next_val", out_rd_val, 32'h99);
    chk("bp_next_pc", out_pc, 32'h404);
    step();
    chk("bp_empty", out_valid, 1'b0);

    // Misaligned word load at 0x6
`ifdef MEM_ALIGN_CHECK_EN
    drv(1'b1, 1'b0, 2'd2, 1'b0, 32'h6, 5'd7, 32'h0, 32'h0, 32'h500);
    step();
    in_valid = 1'b0;
    chk("mis_req", m32.req, 1'b0);
    chk("mis_ov", out_valid, 1'b1);
    chk("mis_exc", out_exc, 1'b1);
    chk("mis_rd", out_rd, 5'd0);
    drv(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 5'd8, 32'h1, 32'h0, 32'h504);
    step();
    in_valid = 1'b0;
    chk("mis_clr_exc", out_exc, 1'b0);
    chk("mis_clr_rd", out_rd, 5'd8);
`else
    run_ld("lw_mis", 32'h6, 2'd2, 1'b0, 32'hCAFE_F00D, 0, 0, 32'h4, 4'hF, 32'hCAFE_F00D);
    chk("mis_exc", out_exc, 1'b0);
`endif

    // Reset in the middle of a load awaiting gnt
    drv(1'b1, 1'b0, 2'd2, 1'b0, 32'h10, 5'd3, 32'h0, 32'h0, 32'h600);
    step();
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("rml_req", m32.req, 1'b1);
      step();
    end
    rst_n = 1'b0;
    #1;
    chk("rml_req0", m32.req, 1'b0);
    chk("rml_ov0", out_valid, 1'b0);
    step();
    rst_n = 1'b1;
    step();
    m32.rvalid = 1'b1;
    m32.rdata  = 32'h7777_7777;
    step();
    m32.rvalid = 1'b0;
    chk("rml_late_ov", out_valid, 1'b0);
    chk("rml_late_req", m32.req, 1'b0);
    chk("rml_rdy", in_ready, 1'b1);

    // 64-bit double load at 0x8
    in_valid64 = 1'b1; in_ld64 = 1'b1; in_size64 = 2'd3; in_addr64 = 32'h8;
    in_rd64 = 5'd10; in_pc64 = 32'h700;
    step();
    in_valid64 = 1'b0;
    chk("ld64_req", m64.req, 1'b1);
    chk("ld64_be", m64.be, 8'hFF);
    chk("ld64_addr", m64.addr, 32'h8);
    m64.gnt = 1'b1;
    step();
    m64.gnt    = 1'b0;
    m64.rvalid = 1'b1;
    m64.rdata  = 64'h0123_4567_89AB_CDEF;
    step();
    m64.rvalid = 1'b0;
    chk("ld64_ov", out_valid64, 1'b1);
    chk("ld64_rd", out_rd64, 5'd10);
    chk("ld64_val", out_rd_val64, 64'h0123_4567_89AB_CDEF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
